// File: rtl/uart_serializer.sv
// Parallel-to-serial UART transmitter: start bit, WIDTH data bits LSB first,
// optional parity, 1 or 2 stop bits, each held for CLKS_PER_BIT clocks.
module uart_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             send,
  output logic             busy,
  output logic             done,
  output logic             txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [BW-1:0]    bit_idx, bit_nxt;
  logic             stop_idx, stop_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             par, par_nxt;
  logic             txd_nxt, busy_nxt, done_nxt;

  // Even parity is the XOR-reduce of the word; odd parity inverts it.
  function automatic logic parity_of(input logic [WIDTH-1:0] word);
    return (^word) ^ (PARITY == 2);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par      <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      stop_idx <= stop_nxt;
      shreg    <= shreg_nxt;
      par      <= par_nxt;
      txd      <= txd_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // txd is computed one cycle ahead so the pin itself is a flop output.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    stop_nxt  = stop_idx;
    shreg_nxt = shreg;
    par_nxt   = par;
    txd_nxt   = txd;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (send) begin
          state_nxt = START;
          cnt_nxt   = CNT_LAST;
          bit_nxt   = '0;
          stop_nxt  = 1'b0;
          shreg_nxt = data;
          par_nxt   = parity_of(data);
          txd_nxt   = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_nxt = DATA;
          cnt_nxt   = CNT_LAST;
          txd_nxt   = shreg[0];
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_nxt = CNT_LAST;
          if (bit_idx == BIT_LAST) begin
            if (PARITY != 0) begin
              state_nxt = PAR;
              txd_nxt   = par;
            end else begin
              state_nxt = STOP;
              txd_nxt   = 1'b1;
            end
          end else begin
            shreg_nxt = shreg >> 1;
            txd_nxt   = shreg_nxt[0];
            bit_nxt   = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PAR: begin
        if (cnt == '0) begin
          state_nxt = STOP;
          cnt_nxt   = CNT_LAST;
          txd_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          cnt_nxt = CNT_LAST;
          if (stop_idx == STOP_LAST) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            txd_nxt   = 1'b1;
          end else begin
            stop_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_serializer.sv
// Scoreboard bench for uart_serializer: three instances with different framing,
// expected frames queued at stimulus time and checked by a txd/busy/done monitor.
module tb_uart_serializer;

  typedef struct {
    int          inst;
    logic [15:0] bits;   // bit 0 is transmitted first
    int          nbits;
    int          cpb;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic [2:0] send_v;
  logic [2:0] busy_v, done_v, txd_v;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt [3];
  int   cyc      [3];
  logic [63:0] cap [3];
  logic prev_busy [3];
  logic done_bad  [3];
  logic chk_next  [3];

  uart_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .data(data), .send(send_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .txd(txd_v[0]));
  uart_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .data(data), .send(send_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .txd(txd_v[1]));
  uart_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .data(data), .send(send_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .txd(txd_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Frame with hand-supplied parity bit; data bits are placed LSB first.
  function automatic exp_t mk(input int inst, input logic [7:0] d, input int has_par,
                              input logic pbit, input int stops);
    exp_t e;
    int   n;
    e.inst = inst;
    e.cpb  = 4;
    e.bits = '0;
    for (int k = 0; k < 8; k++) e.bits[1+k] = d[k];
    n = 9;
    if (has_par != 0) begin
      e.bits[n] = pbit;
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nbits = n;
    return e;
  endfunction

  task automatic end_frame(input int i);
    exp_t        e;
    logic [63:0] stream;
    if (q.size() == 0) begin
      check("unexpected_frame", 64'(i), 64'hFFFF);
      return;
    end
    e = q.pop_front();
    stream = '0;
    for (int c = 0; c < e.nbits * e.cpb; c++) stream[c] = e.bits[c / e.cpb];
    check("frame_inst", 64'(i), 64'(e.inst));
    check("busy_len", 64'(cyc[i]), 64'(e.nbits * e.cpb));
    check("frame_bits", cap[i], stream);
    check("done_at_end", {62'd0, done_v[i], txd_v[i]}, 64'd3);
    check("done_in_frame", 64'(done_bad[i]), 64'd0);
    chk_next[i] = 1'b1;
  endtask

  // Monitor: samples on the falling edge, captures txd while busy.
  initial begin
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0; cyc[i] = 0; cap[i] = '0;
      prev_busy[i] = 1'b0; done_bad[i] = 1'b0; chk_next[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (chk_next[i]) begin
          check("done_one_cycle", 64'(done_v[i]), 64'd0);
          chk_next[i] = 1'b0;
        end
        if (!rst) begin
          prev_busy[i] = 1'b0;
        end else begin
          if (busy_v[i]) begin
            if (!prev_busy[i]) begin
              cyc[i] = 0; cap[i] = '0; done_bad[i] = 1'b0;
            end
            if (cyc[i] < 64) cap[i][cyc[i]] = txd_v[i];
            cyc[i]++;
            if (done_v[i]) done_bad[i] = 1'b1;
          end else if (prev_busy[i]) begin
            end_frame(i);
          end
          if (done_v[i]) done_cnt[i]++;
          prev_busy[i] = busy_v[i];
        end
      end
    end
  end

  task automatic wait_done(input int i, input int lim);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_v[i] && k < lim);
    if (!done_v[i]) check("done_timeout", 64'(k), 64'(lim + 1));
  endtask

  task automatic send_one(input int i, input logic [7:0] d);
    @(negedge clk);
    data = d;
    send_v[i] = 1'b1;
    @(negedge clk);
    send_v[i] = 1'b0;
  endtask

  initial begin
    int d0;
    rst    = 1'b0;
    send_v = 3'b001;
    data   = 8'h5A;

    // Reset with send held high: outputs idle, frame starts on first edge after release.
    repeat (3) @(negedge clk);
    check("rst_txd", 64'(txd_v[0]), 64'd1);
    check("rst_busy", 64'(busy_v[0]), 64'd0);
    check("rst_done", 64'(done_v[0]), 64'd0);
    q.push_back(mk(0, 8'h5A, 0, 1'b0, 1));
    #1 rst = 1'b1;
    @(negedge clk);
    check("start_after_rst", {62'd0, busy_v[0], txd_v[0]}, 64'd2);
    send_v[0] = 1'b0;
    wait_done(0, 100);

    // 0xA5 on the default framing: 0,1,0,1,0,0,1,0,1,1
    q.push_back('{inst: 0, bits: 16'b0000_0011_0100_1010, nbits: 10, cpb: 4});
    send_one(0, 8'hA5);
    wait_done(0, 100);

    // Even and odd parity, two stop bits
    q.push_back(mk(1, 8'hA5, 1, 1'b0, 2));
    send_one(1, 8'hA5);
    wait_done(1, 100);
    q.push_back(mk(2, 8'hA5, 1, 1'b1, 2));
    send_one(2, 8'hA5);
    wait_done(2, 100);
    q.push_back(mk(1, 8'h07, 1, 1'b1, 2));
    send_one(1, 8'h07);
    wait_done(1, 100);

    // Send pulse and data change mid-frame must be ignored
    q.push_back(mk(0, 8'h3C, 0, 1'b0, 1));
    send_one(0, 8'h3C);
    repeat (10) @(negedge clk);
    data = 8'hFF;
    send_v[0] = 1'b1;
    @(negedge clk);
    send_v[0] = 1'b0;
    wait_done(0, 100);
    repeat (6) @(negedge clk);
    check("idle_after_ignored", 64'(busy_v[0]), 64'd0);

    // Back-to-back with send held high
    #1 d0 = done_cnt[0];
    q.push_back(mk(0, 8'h01, 0, 1'b0, 1));
    q.push_back(mk(0, 8'h80, 0, 1'b0, 1));
    @(negedge clk);
    data = 8'h01;
    send_v[0] = 1'b1;
    @(negedge clk);
    data = 8'h80;
    wait_done(0, 100);
    @(negedge clk);
    check("b2b_start", {62'd0, busy_v[0], txd_v[0]}, 64'd2);
    send_v[0] = 1'b0;
    wait_done(0, 100);
    @(negedge clk);
    #1 check("b2b_done_count", 64'(done_cnt[0] - d0), 64'd2);

    // Asynchronous reset during data bit 3 (0x07 has bit 3 = 0)
    send_one(0, 8'h07);
    repeat (17) @(negedge clk);
    check("pre_abort_txd", 64'(txd_v[0]), 64'd0);
    #1 rst = 1'b0;
    #1;
    check("abort_txd", 64'(txd_v[0]), 64'd1);
    check("abort_busy", 64'(busy_v[0]), 64'd0);
    check("abort_done", 64'(done_v[0]), 64'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    q.push_back(mk(0, 8'h55, 0, 1'b0, 1));
    send_one(0, 8'h55);
    wait_done(0, 100);

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
